// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I writeback path: writeback source codes
// (shared with the mux select unit) and the writeback control state encoding.
package riscv_pkg;

    localparam logic [2:0] WB_ALU       = 3'b000;
    localparam logic [2:0] WB_LU        = 3'b001;
    localparam logic [2:0] WB_IMM       = 3'b010;
    localparam logic [2:0] WB_IADDER    = 3'b011;
    localparam logic [2:0] WB_CSR       = 3'b100;
    localparam logic [2:0] WB_PC_PLUS_4 = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_WB        = 2'b01,
        S_LOAD_WAIT = 2'b10
    } wb_state_t;

    // Reserved codes 110/111 collapse to ALU so the mux unit never sees them.
    function automatic logic [2:0] wb_sel_norm(input logic [2:0] sel);
        return (sel > WB_PC_PLUS_4) ? WB_ALU : sel;
    endfunction

endpackage

// File: rtl/wb_ctrl_unit.sv
// Writeback control sequencer: holds decode mux selects and rd for the mux unit
// and register file, and stalls loads until dmem acknowledge or timeout.
//
// state       | meaning
// S_IDLE      | no instruction held
// S_WB        | non-load instruction held, write strobe this cycle
// S_LOAD_WAIT | load held, waiting for dmem_ack_in
module wb_ctrl_unit
    import riscv_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 8
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       valid_in,
    input  logic [2:0] wb_mux_sel_in,
    input  logic       alu_source_in,
    input  logic [4:0] rd_addr_in,
    input  logic       rf_wr_en_in,
    input  logic       flush_in,
    input  logic       dmem_ack_in,
    output logic       ready_out,
    output logic [2:0] wb_mux_sel_reg_out,
    output logic       alu_source_reg_out,
    output logic [4:0] rd_addr_reg_out,
    output logic       rf_wr_en_out,
    output logic       load_fault_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    wb_state_t        state_q;
    logic [2:0]       sel_q;
    logic             alu_src_q;
    logic [4:0]       rd_q;
    logic             wr_en_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fault_q;

    logic             accept;
    logic [2:0]       sel_d;
    logic             wr_en_d;

    assign ready_out = !flush_in && ((state_q != S_LOAD_WAIT) || dmem_ack_in);
    assign accept    = valid_in && ready_out;
    assign sel_d     = wb_sel_norm(wb_mux_sel_in);
    assign wr_en_d   = rf_wr_en_in && (rd_addr_in != 5'd0);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= S_IDLE;
            sel_q     <= WB_ALU;
            alu_src_q <= 1'b0;
            rd_q      <= 5'd0;
            wr_en_q   <= 1'b0;
            cnt_q     <= '0;
            fault_q   <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            if (flush_in) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else if (accept) begin
                state_q   <= (sel_d == WB_LU) ? S_LOAD_WAIT : S_WB;
                sel_q     <= sel_d;
                alu_src_q <= alu_source_in;
                rd_q      <= rd_addr_in;
                wr_en_q   <= wr_en_d;
                cnt_q     <= '0;
            end else begin
                case (state_q)
                    S_WB: state_q <= S_IDLE;
                    S_LOAD_WAIT: begin
                        if (dmem_ack_in) begin
                            state_q <= S_IDLE;
                        end else if (cnt_q == CNT_LAST) begin
                            // Timed-out load is dropped; no write is issued.
                            state_q <= S_IDLE;
                            fault_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        rf_wr_en_out = 1'b0;
        if (!flush_in) begin
            case (state_q)
                S_WB:        rf_wr_en_out = wr_en_q;
                S_LOAD_WAIT: rf_wr_en_out = wr_en_q && dmem_ack_in;
                default:     rf_wr_en_out = 1'b0;
            endcase
        end
    end

    assign wb_mux_sel_reg_out = sel_q;
    assign alu_source_reg_out = alu_src_q;
    assign rd_addr_reg_out    = rd_q;
    assign load_fault_out     = fault_q;

endmodule

// File: tb/tb_wb_ctrl_unit.sv
// Directed bench for wb_ctrl_unit: issue, load stall/ack, timeout, flush,
// back-to-back issue and asynchronous reset.
module tb_wb_ctrl_unit;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       valid_in;
    logic [2:0] wb_mux_sel_in;
    logic       alu_source_in;
    logic [4:0] rd_addr_in;
    logic       rf_wr_en_in;
    logic       flush_in;
    logic       dmem_ack_in;
    logic       ready_out;
    logic [2:0] wb_mux_sel_reg_out;
    logic       alu_source_reg_out;
    logic [4:0] rd_addr_reg_out;
    logic       rf_wr_en_out;
    logic       load_fault_out;

    int tests_run = 0;
    int tests_failed = 0;

    wb_ctrl_unit #(.LOAD_TIMEOUT(16), .CNT_W(8)) dut (
        .clk_in             (clk_in),
        .reset_in           (reset_in),
        .valid_in           (valid_in),
        .wb_mux_sel_in      (wb_mux_sel_in),
        .alu_source_in      (alu_source_in),
        .rd_addr_in         (rd_addr_in),
        .rf_wr_en_in        (rf_wr_en_in),
        .flush_in           (flush_in),
        .dmem_ack_in        (dmem_ack_in),
        .ready_out          (ready_out),
        .wb_mux_sel_reg_out (wb_mux_sel_reg_out),
        .alu_source_reg_out (alu_source_reg_out),
        .rd_addr_reg_out    (rd_addr_reg_out),
        .rf_wr_en_out       (rf_wr_en_out),
        .load_fault_out     (load_fault_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then changed and
    // checks made one time unit later, well clear of either edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [2:0] sel, input logic [4:0] rd,
                         input logic wen, input logic alu);
        valid_in      = 1'b1;
        wb_mux_sel_in = sel;
        rd_addr_in    = rd;
        rf_wr_en_in   = wen;
        alu_source_in = alu;
    endtask

    initial begin
        reset_in = 1'b1; valid_in = 1'b0; wb_mux_sel_in = 3'b0; alu_source_in = 1'b0;
        rd_addr_in = 5'd0; rf_wr_en_in = 1'b0; flush_in = 1'b0; dmem_ack_in = 1'b0;
        #3;
        chk("rst_ready", 8'(ready_out), 8'd1);
        chk("rst_wen", 8'(rf_wr_en_out), 8'd0);
        chk("rst_fault", 8'(load_fault_out), 8'd0);
        chk("rst_sel", 8'(wb_mux_sel_reg_out), 8'd0);
        chk("rst_rd", 8'(rd_addr_reg_out), 8'd0);
        chk("rst_alu", 8'(alu_source_reg_out), 8'd0);
        @(negedge clk_in);
        reset_in = 1'b0;

        // ALU op to rd=5: strobe one cycle after accept, then idle.
        issue(3'b000, 5'd5, 1'b1, 1'b0);
        tick(); valid_in = 1'b0; #1;
        chk("alu_wen", 8'(rf_wr_en_out), 8'd1);
        chk("alu_rd", 8'(rd_addr_reg_out), 8'd5);
        chk("alu_sel", 8'(wb_mux_sel_reg_out), 8'd0);
        tick(); #1;
        chk("alu_wen_off", 8'(rf_wr_en_out), 8'd0);
        chk("alu_ready", 8'(ready_out), 8'd1);

        // Load rd=7, ack in the third cycle after accept.
        issue(3'b001, 5'd7, 1'b1, 1'b0);
        tick(); valid_in = 1'b0; #1;
        chk("ld_c1_ready", 8'(ready_out), 8'd0);
        chk("ld_c1_wen", 8'(rf_wr_en_out), 8'd0);
        tick(); #1;
        chk("ld_c2_ready", 8'(ready_out), 8'd0);
        chk("ld_c2_wen", 8'(rf_wr_en_out), 8'd0);
        tick(); dmem_ack_in = 1'b1; #1;
        chk("ld_ack_ready", 8'(ready_out), 8'd1);
        chk("ld_ack_wen", 8'(rf_wr_en_out), 8'd1);
        chk("ld_ack_rd", 8'(rd_addr_reg_out), 8'd7);
        chk("ld_ack_sel", 8'(wb_mux_sel_reg_out), 8'd1);
        tick(); dmem_ack_in = 1'b0; #1;
        chk("ld_done_wen", 8'(rf_wr_en_out), 8'd0);
        chk("ld_done_ready", 8'(ready_out), 8'd1);

        // Load with no ack: fault exactly 16 cycles after accept.
        issue(3'b001, 5'd9, 1'b1, 1'b0);
        tick(); valid_in = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            #1;
            chk($sformatf("to_c%0d_fault", i), 8'(load_fault_out), 8'd0);
            chk($sformatf("to_c%0d_wen", i), 8'(rf_wr_en_out), 8'd0);
            chk($sformatf("to_c%0d_ready", i), 8'(ready_out), 8'd0);
            tick();
        end
        #1;
        chk("to_fault", 8'(load_fault_out), 8'd1);
        chk("to_ready", 8'(ready_out), 8'd1);
        chk("to_wen", 8'(rf_wr_en_out), 8'd0);
        tick(); #1;
        chk("to_fault_pulse", 8'(load_fault_out), 8'd0);

        // Ack on the last cycle before timeout wins.
        issue(3'b001, 5'd8, 1'b1, 1'b0);
        tick(); valid_in = 1'b0;
        for (int i = 1; i <= 15; i++) tick();
        dmem_ack_in = 1'b1; #1;
        chk("late_ack_wen", 8'(rf_wr_en_out), 8'd1);
        tick(); dmem_ack_in = 1'b0; #1;
        chk("late_ack_nofault", 8'(load_fault_out), 8'd0);
        chk("late_ack_ready", 8'(ready_out), 8'd1);

        // rd=0 never written; alu_source captured; reserved sel maps to ALU.
        issue(3'b010, 5'd0, 1'b1, 1'b1);
        tick(); valid_in = 1'b0; alu_source_in = 1'b0; #1;
        chk("x0_wen", 8'(rf_wr_en_out), 8'd0);
        chk("x0_alu_src", 8'(alu_source_reg_out), 8'd1);
        chk("x0_sel", 8'(wb_mux_sel_reg_out), 8'd2);
        issue(3'b110, 5'd2, 1'b1, 1'b0);
        tick(); valid_in = 1'b0; #1;
        chk("rsv_sel", 8'(wb_mux_sel_reg_out), 8'd0);
        chk("rsv_wen", 8'(rf_wr_en_out), 8'd1);
        chk("rsv_ready", 8'(ready_out), 8'd1);
        tick(); #1;

        // Flush in load-wait cycle 2 (with a valid that must be dropped).
        issue(3'b001, 5'd10, 1'b1, 1'b0);
        tick(); valid_in = 1'b0; #1;
        tick(); flush_in = 1'b1; issue(3'b000, 5'd11, 1'b1, 1'b0); #1;
        chk("fl_ready", 8'(ready_out), 8'd0);
        chk("fl_wen", 8'(rf_wr_en_out), 8'd0);
        tick(); flush_in = 1'b0; valid_in = 1'b0; #1;
        chk("fl_c3_ready", 8'(ready_out), 8'd1);
        chk("fl_c3_wen", 8'(rf_wr_en_out), 8'd0);
        chk("fl_c3_rd", 8'(rd_addr_reg_out), 8'd10);
        tick(); dmem_ack_in = 1'b1; #1;
        chk("fl_ack_wen", 8'(rf_wr_en_out), 8'd0);
        chk("fl_ack_ready", 8'(ready_out), 8'd1);
        tick(); dmem_ack_in = 1'b0; #1;
        chk("fl_nofault", 8'(load_fault_out), 8'd0);

        // Flush masks the strobe of a held non-load instruction.
        issue(3'b000, 5'd6, 1'b1, 1'b0);
        tick(); valid_in = 1'b0; flush_in = 1'b1; #1;
        chk("fl_wb_wen", 8'(rf_wr_en_out), 8'd0);
        tick(); flush_in = 1'b0; #1;

        // Back-to-back imm then csr.
        issue(3'b010, 5'd3, 1'b1, 1'b0);
        tick(); issue(3'b100, 5'd4, 1'b1, 1'b0); #1;
        chk("b2b_1_wen", 8'(rf_wr_en_out), 8'd1);
        chk("b2b_1_rd", 8'(rd_addr_reg_out), 8'd3);
        chk("b2b_1_ready", 8'(ready_out), 8'd1);
        tick(); valid_in = 1'b0; #1;
        chk("b2b_2_wen", 8'(rf_wr_en_out), 8'd1);
        chk("b2b_2_rd", 8'(rd_addr_reg_out), 8'd4);
        chk("b2b_2_sel", 8'(wb_mux_sel_reg_out), 8'd4);
        tick(); #1;
        chk("b2b_idle_wen", 8'(rf_wr_en_out), 8'd0);

        // Issue on the ack cycle of a minimum-latency load.
        issue(3'b001, 5'd12, 1'b1, 1'b0);
        tick(); dmem_ack_in = 1'b1; issue(3'b011, 5'd13, 1'b1, 1'b0); #1;
        chk("ackiss_wen", 8'(rf_wr_en_out), 8'd1);
        chk("ackiss_rd", 8'(rd_addr_reg_out), 8'd12);
        chk("ackiss_ready", 8'(ready_out), 8'd1);
        tick(); dmem_ack_in = 1'b0; valid_in = 1'b0; #1;
        chk("ackiss_2_wen", 8'(rf_wr_en_out), 8'd1);
        chk("ackiss_2_rd", 8'(rd_addr_reg_out), 8'd13);
        chk("ackiss_2_sel", 8'(wb_mux_sel_reg_out), 8'd3);

        // Async reset mid-load clears immediately; a later ack is ignored.
        issue(3'b001, 5'd14, 1'b1, 1'b1);
        tick(); valid_in = 1'b0; #1;
        chk("mr_pre_ready", 8'(ready_out), 8'd0);
        reset_in = 1'b1; #1;
        chk("mr_ready", 8'(ready_out), 8'd1);
        chk("mr_rd", 8'(rd_addr_reg_out), 8'd0);
        chk("mr_sel", 8'(wb_mux_sel_reg_out), 8'd0);
        chk("mr_alu", 8'(alu_source_reg_out), 8'd0);
        chk("mr_wen", 8'(rf_wr_en_out), 8'd0);
        @(negedge clk_in);
        reset_in = 1'b0;
        tick(); dmem_ack_in = 1'b1; #1;
        chk("mr_ack_wen", 8'(rf_wr_en_out), 8'd0);
        tick(); dmem_ack_in = 1'b0; #1;
        chk("mr_fault", 8'(load_fault_out), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_ctrl_unit.md
Name: wb_ctrl_unit

Overview:
- Control sequencer for the writeback / ALU-operand mux datapath of the RV32I core.
- Captures the per-instruction mux selects and destination register from decode, and holds them stable for the mux unit.
- Generates the register-file write strobe, stalling on loads until the data-memory acknowledge arrives.
- Handles pipeline flush and load timeout. Sits between decode/issue and the mux select unit plus register file.

Parameters:
- LOAD_TIMEOUT, 16, max cycles spent in S_LOAD_WAIT before a fault is raised (legal range 2..255).
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > LOAD_TIMEOUT.

Ports:
- clk_in  input  1  core clock; all state updates on the rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- valid_in  input  1  decode presents a valid instruction.
- wb_mux_sel_in  input  3  writeback source select for the instruction.
- alu_source_in  input  1  ALU 2nd-operand select (0 = rs2, 1 = imm).
- rd_addr_in  input  5  destination register.
- rf_wr_en_in  input  1  instruction writes rd.
- flush_in  input  1  kill the in-flight instruction (trap/branch redirect).
- dmem_ack_in  input  1  load data valid on lu_output this cycle.
- ready_out  output  1  block accepts an instruction this cycle.
- wb_mux_sel_reg_out  output  3  registered writeback select to the mux unit.
- alu_source_reg_out  output  1  registered ALU source select to the mux unit.
- rd_addr_reg_out  output  5  registered rd to the register file.
- rf_wr_en_out  output  1  register-file write strobe.
- load_fault_out  output  1  one-cycle pulse on load timeout.

Behaviour:
- Writeback select encoding: 000 ALU, 001 LU, 010 IMM, 011 IADDER, 100 CSR, 101 PC_PLUS_4. Codes 110/111 are treated as ALU.
- Reset values (asynchronous): state S_IDLE, all registered outputs 0, counter 0, load_fault_out 0. ready_out is 1 after reset because it is combinational.
- States:
  - S_IDLE: no instruction held.
  - S_WB: non-load instruction held.
  - S_LOAD_WAIT: load held, awaiting acknowledge.
- Accept: a transfer occurs when valid_in & ready_out. On accept, capture sel, alu_source, rd, and wr_en_q.
  - wr_en_q = rf_wr_en_in & (rd_addr_in != 0); x0 is never written.
  - Next state is S_LOAD_WAIT if sel == LU, else S_WB.
  - Counter clears to 0 on accept.
- ready_out = !flush_in & (state != S_LOAD_WAIT | dmem_ack_in). Back-to-back issue is allowed from S_WB and on the acknowledge cycle of a load.
- rf_wr_en_out (combinational from state and registers):
  - In S_WB: wr_en_q.
  - In S_LOAD_WAIT: wr_en_q & dmem_ack_in.
  - Otherwise: 0.
  - Forced to 0 whenever flush_in = 1.
- Latency:
  - Non-load: write strobe 1 cycle after accept.
  - Load: write strobe in the cycle dmem_ack_in is high; minimum 1 cycle after accept.
- Returning to idle:
  - From S_WB with no new accept: go to S_IDLE.
  - From S_LOAD_WAIT on ack with no new accept: go to S_IDLE.
  - Registered selects keep their last values while idle and do not return to 0.
- Timeout:
  - In S_LOAD_WAIT without ack, the counter increments each cycle.
  - When counter == LOAD_TIMEOUT-1 and no ack, the next edge does all of the following: load_fault_out = 1 for one cycle, state goes to S_IDLE, no write occurs.
  - An ack in that same cycle wins: normal write, no fault.
- Flush (highest priority):
  - Next state is S_IDLE and the counter clears; nothing is accepted in the flush cycle.
  - A pending load is abandoned; a late dmem_ack_in in S_IDLE is ignored.
- Reset mid-load: immediate return to S_IDLE, no write strobe and no fault.

Decomposition:
- Shared package riscv_pkg holds:
  - WB_ALU..WB_PC_PLUS_4 localparams (3-bit), shared with the mux select unit.
  - State encodings S_IDLE/S_WB/S_LOAD_WAIT (2-bit).
- No sub-module is needed beyond an optional load_timer (counter plus compare) if the team prefers it isolated; the single-module form is the default.

Test Plan:
- Reset, then valid_in=1, sel=000, rd=5, wr_en=1 → next cycle rf_wr_en_out=1, rd_addr_reg_out=5, wb_mux_sel_reg_out=000; the following cycle rf_wr_en_out=0.
- Load: sel=001, rd=7, ack 3 cycles after accept → ready_out=0 for 2 cycles; rf_wr_en_out=1 only in the ack cycle; ready_out=1 in the ack cycle.
- Load with no ack, LOAD_TIMEOUT=16 → load_fault_out pulses exactly 16 cycles after accept, rf_wr_en_out never rises, state returns to idle (ready_out=1).
- Non-load instruction with rd=0, wr_en=1 → rf_wr_en_out stays 0; alu_source_in=1 appears on alu_source_reg_out 1 cycle later.
- Flush during load wait (cycle 2), ack in cycle 4 → no write, no fault, ready_out=1 from cycle 3.
- Back-to-back: imm (sel=010, rd=3) then csr (sel=100, rd=4) on consecutive cycles → rf_wr_en_out high two consecutive cycles with rd 3 then 4; async reset asserted mid-stream clears all outputs immediately.
